// File: rtl/uart_num_parser.sv
// Turns a stream of ASCII UART bytes into signed decimal numbers separated by space/CR/LF.
// Optional negative-number support is enabled by defining NUM_PARSER_NEG_EN.
module uart_num_parser #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_clear,
  output logic              o_num_valid,
  output logic [DATA_W-1:0] o_num_value,
  output logic              o_err,
  output logic              o_err_sticky,
  output logic [CNT_W-1:0]  o_num_count
);

  typedef enum logic [1:0] {IDLE, NUM, SKIP} state_t;

  // Four extra bits hold acc*10+9 without wrapping, so overflow is a plain compare.
  localparam int EXT_W = DATA_W + 4;
  localparam logic [EXT_W-1:0] NEG_LIMIT = EXT_W'(1) << (DATA_W - 1);
  localparam logic [EXT_W-1:0] POS_LIMIT = NEG_LIMIT - EXT_W'(1);

  state_t             state, state_next;
  logic [DATA_W-1:0]  acc, acc_next;
  logic [DATA_W-1:0]  emit_value;
  logic [EXT_W-1:0]   acc_ext;
  logic [EXT_W-1:0]   limit;
  logic               is_digit, is_delim, overflow;
  logic               emit, err;

  assign is_digit = (i_rx_byte >= 8'h30) && (i_rx_byte <= 8'h39);
  assign is_delim = (i_rx_byte == 8'h20) || (i_rx_byte == 8'h0D) || (i_rx_byte == 8'h0A);
  assign acc_ext  = ({4'b0000, acc} * EXT_W'(10)) + EXT_W'(i_rx_byte[3:0]);
  assign overflow = acc_ext > limit;

`ifdef NUM_PARSER_NEG_EN
  logic is_minus, neg, neg_next, has_digit, has_next;
  assign is_minus   = (i_rx_byte == 8'h2D);
  assign limit      = neg ? NEG_LIMIT : POS_LIMIT;
  assign emit_value = neg ? (~acc + DATA_W'(1)) : acc;
`else
  assign limit      = POS_LIMIT;
  assign emit_value = acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    emit       = 1'b0;
    err        = 1'b0;
`ifdef NUM_PARSER_NEG_EN
    neg_next   = neg;
    has_next   = has_digit;
`endif
    if (i_clear) begin
      state_next = IDLE;
      acc_next   = '0;
    end else if (i_rx_valid) begin
      case (state)
        IDLE: begin
          if (is_digit) begin
            acc_next   = DATA_W'(i_rx_byte[3:0]);
            state_next = NUM;
`ifdef NUM_PARSER_NEG_EN
            neg_next   = 1'b0;
            has_next   = 1'b1;
          end else if (is_minus) begin
            acc_next   = '0;
            state_next = NUM;
            neg_next   = 1'b1;
            has_next   = 1'b0;
`endif
          end else if (!is_delim) begin
            err        = 1'b1;
            state_next = SKIP;
          end
        end
        NUM: begin
          if (is_digit) begin
            if (overflow) begin
              err        = 1'b1;
              state_next = SKIP;
            end else begin
              acc_next   = acc_ext[DATA_W-1:0];
`ifdef NUM_PARSER_NEG_EN
              has_next   = 1'b1;
`endif
            end
          end else if (is_delim) begin
            state_next = IDLE;
`ifdef NUM_PARSER_NEG_EN
            if (!has_digit) begin
              err        = 1'b1;
              state_next = SKIP;
            end else begin
              emit       = 1'b1;
            end
`else
            emit       = 1'b1;
`endif
          end else begin
            err        = 1'b1;
            state_next = SKIP;
          end
        end
        SKIP: begin
          if (is_delim) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are registered, so strobes appear one edge after the byte is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      o_num_valid  <= 1'b0;
      o_num_value  <= '0;
      o_err        <= 1'b0;
      o_err_sticky <= 1'b0;
      o_num_count  <= '0;
`ifdef NUM_PARSER_NEG_EN
      neg          <= 1'b0;
      has_digit    <= 1'b0;
`endif
    end else begin
      acc         <= acc_next;
      o_num_valid <= emit;
      o_err       <= err;
`ifdef NUM_PARSER_NEG_EN
      neg         <= neg_next;
      has_digit   <= has_next;
`endif
      if (emit) begin
        o_num_value <= emit_value;
        o_num_count <= o_num_count + CNT_W'(1);
      end
      if (i_clear) begin
        o_err_sticky <= 1'b0;
        o_num_count  <= '0;
      end else if (err) begin
        o_err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_num_parser.sv
// Scoreboard bench for uart_num_parser: expected numbers are queued as stimulus is
// driven and compared against the strobes the parser produces.
module tb_uart_num_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_byte = 8'h00;
  logic        i_clear = 1'b0;
  logic        o_num_valid;
  logic [31:0] o_num_value;
  logic        o_err;
  logic        o_err_sticky;
  logic [7:0]  o_num_count;

  int          checks = 0;
  int          failures = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  uart_num_parser #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte),
    .i_clear(i_clear), .o_num_valid(o_num_valid), .o_num_value(o_num_value),
    .o_err(o_err), .o_err_sticky(o_err_sticky), .o_num_count(o_num_count)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the edge that consumed the byte.
  task automatic sample_outputs();
    if (o_num_valid) obs_q.push_back(o_num_value);
    if (o_err) err_cnt++;
    if (o_num_valid && o_err) both_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic clr);
    i_rx_valid = 1'b1;
    i_rx_byte  = b;
    i_clear    = clr;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    i_clear    = 1'b0;
    sample_outputs();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      sample_outputs();
    end
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    sample_outputs();
    obs_q.delete();
    exp_q.delete();
    err_cnt = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (o_num_valid !== 1'b0)  begin failures++; $display("[TB] FAIL reset_valid got %b want 0", o_num_valid); end
    checks++; if (o_num_value !== 32'h0) begin failures++; $display("[TB] FAIL reset_value got %h want 0", o_num_value); end
    checks++; if (o_err !== 1'b0)        begin failures++; $display("[TB] FAIL reset_err got %b want 0", o_err); end
    checks++; if (o_err_sticky !== 1'b0) begin failures++; $display("[TB] FAIL reset_sticky got %b want 0", o_err_sticky); end
    checks++; if (o_num_count !== 8'h0)  begin failures++; $display("[TB] FAIL reset_count got %0d want 0", o_num_count); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_clear();
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    send_str("2 3 ");
    idle_cycles(2);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL basic_emits got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL basic_value[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (err_cnt !== 0)         begin failures++; $display("[TB] FAIL basic_errs got %0d want 0", err_cnt); end
    checks++; if (o_num_count !== 8'd2)  begin failures++; $display("[TB] FAIL basic_count got %0d want 2", o_num_count); end
  endtask

  task automatic test_error();
    do_clear();
    exp_q.push_back(32'd4);
    send_str("12x5 4 ");
    idle_cycles(2);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL error_emits got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL error_value[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (err_cnt !== 1)         begin failures++; $display("[TB] FAIL error_errs got %0d want 1", err_cnt); end
    checks++; if (o_err_sticky !== 1'b1) begin failures++; $display("[TB] FAIL error_sticky got %b want 1", o_err_sticky); end
    checks++; if (o_num_count !== 8'd1)  begin failures++; $display("[TB] FAIL error_count got %0d want 1", o_num_count); end
  endtask

  task automatic test_overflow();
    do_clear();
    send_str("214748364");
    checks++; if (err_cnt !== 0) begin failures++; $display("[TB] FAIL ovf_early_err got %0d want 0", err_cnt); end
    send_str("8");
    checks++; if (err_cnt !== 1) begin failures++; $display("[TB] FAIL ovf_last_digit_err got %0d want 1", err_cnt); end
    exp_q.push_back(32'h7FFF_FFFF);
    send_str(" 2147483647 ");
    idle_cycles(2);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL ovf_emits got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL ovf_value[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (err_cnt !== 1) begin failures++; $display("[TB] FAIL ovf_errs got %0d want 1", err_cnt); end
  endtask

  task automatic test_clear();
    do_clear();
    send_str("z 1 45");
    obs_q.delete();
    err_cnt = 0;
    send_byte(8'h20, 1'b1);
    idle_cycles(2);
    checks++; if (obs_q.size() !== 0)    begin failures++; $display("[TB] FAIL clear_emits got %0d want 0", obs_q.size()); end
    checks++; if (err_cnt !== 0)         begin failures++; $display("[TB] FAIL clear_errs got %0d want 0", err_cnt); end
    checks++; if (o_err_sticky !== 1'b0) begin failures++; $display("[TB] FAIL clear_sticky got %b want 0", o_err_sticky); end
    checks++; if (o_num_count !== 8'd0)  begin failures++; $display("[TB] FAIL clear_count got %0d want 0", o_num_count); end
    exp_q.push_back(32'd6);
    send_str("6 ");
    idle_cycles(1);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL clear_after_emits got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL clear_after_value got %h want %h", obs_q[i], exp_q[i]); end
    end
    checks++; if (o_num_count !== 8'd1)  begin failures++; $display("[TB] FAIL clear_after_count got %0d want 1", o_num_count); end
  endtask

  task automatic test_minus();
    int exp_errs;
    do_clear();
`ifdef NUM_PARSER_NEG_EN
    exp_q.push_back(32'hFFFF_FFF4);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'd3);
    send_str("-12 - -2147483648 -2147483649 1-2 3 ");
    exp_errs = 3;
`else
    exp_q.push_back(32'd3);
    send_str("-1 3 ");
    exp_errs = 1;
`endif
    idle_cycles(2);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL minus_emits got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL minus_value[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (err_cnt !== exp_errs) begin failures++; $display("[TB] FAIL minus_errs got %0d want %0d", err_cnt, exp_errs); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd0);
    send_str("007 \r\n  1");
    idle_cycles(6);
    send_str("0\n0\r");
    idle_cycles(2);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL b2b_emits got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL b2b_value[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (err_cnt !== 0)        begin failures++; $display("[TB] FAIL b2b_errs got %0d want 0", err_cnt); end
    checks++; if (o_num_count !== 8'd3) begin failures++; $display("[TB] FAIL b2b_count got %0d want 3", o_num_count); end
  endtask

  task automatic test_wrap();
    int mismatches = 0;
    do_clear();
    for (int i = 0; i < 257; i++) begin
      exp_q.push_back(32'(i % 10));
      send_byte(8'h30 + 8'(i % 10), 1'b0);
      send_byte(8'h0A, 1'b0);
    end
    idle_cycles(1);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL wrap_emits got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) mismatches++;
    checks++; if (mismatches !== 0)     begin failures++; $display("[TB] FAIL wrap_values got %0d bad want 0", mismatches); end
    checks++; if (o_num_count !== 8'd1) begin failures++; $display("[TB] FAIL wrap_count got %0d want 1", o_num_count); end
  endtask

  task automatic test_async_reset();
    send_str("q 99");
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_num_count !== 8'd0)  begin failures++; $display("[TB] FAIL areset_count got %0d want 0", o_num_count); end
    checks++; if (o_err_sticky !== 1'b0) begin failures++; $display("[TB] FAIL areset_sticky got %b want 0", o_err_sticky); end
    checks++; if (o_num_value !== 32'h0) begin failures++; $display("[TB] FAIL areset_value got %h want 0", o_num_value); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    err_cnt = 0;
    exp_q.push_back(32'd3);
    send_str("3 ");
    idle_cycles(1);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL areset_emits got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL areset_value_after got %h want %h", obs_q[i], exp_q[i]); end
    end
    checks++; if (o_num_count !== 8'd1) begin failures++; $display("[TB] FAIL areset_count_after got %0d want 1", o_num_count); end
    checks++; if (both_cnt !== 0)       begin failures++; $display("[TB] FAIL valid_err_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_overflow();
    test_clear();
    test_minus();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_num_parser.md
UART_NUM_PARSER -- requirements
Module: uart_num_parser

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the emitted value.
REQ-002 SHALL have parameter CNT_W, default 8, width of the emitted-number counter.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_rx_valid  input  1  one-cycle strobe: i_rx_byte holds a received UART byte.
REQ-006 SHALL have port i_rx_byte  input  8  received ASCII byte.
REQ-007 SHALL have port i_clear  input  1  synchronous abort: discard partial token, clear sticky error and counter.
REQ-008 SHALL have port o_num_valid  output  1  one-cycle strobe: o_num_value is a completed number.
REQ-009 SHALL have port o_num_value  output  DATA_W  parsed value, two's complement, held until next strobe.
REQ-010 SHALL have port o_err  output  1  one-cycle strobe on a token error.
REQ-011 SHALL have port o_err_sticky  output  1  set by any token error, cleared only by i_clear or reset.
REQ-012 SHALL have port o_num_count  output  CNT_W  count of numbers emitted since reset/clear.

Function
REQ-013 SHALL classify bytes: digit 0x30-0x39; delimiter 0x20, 0x0D, 0x0A; everything else invalid (except '-' per REQ-027).
REQ-014 SHALL implement states IDLE, NUM, SKIP; IDLE after reset.
REQ-015 IDLE: digit -> load accumulator with digit value, go NUM; delimiter -> stay IDLE, no output; invalid -> o_err, go SKIP.
REQ-016 NUM: digit -> accumulator = accumulator*10 + digit; delimiter -> emit, go IDLE; invalid -> o_err, go SKIP, no emit.
REQ-017 SKIP: ignore digits and invalid bytes; delimiter -> IDLE with no emit and no further o_err.
REQ-018 Emit SHALL assert o_num_valid, update o_num_value and increment o_num_count on the clock edge following the cycle in which the delimiter is sampled (latency 1 cycle).
REQ-019 Overflow: if accumulator*10 + digit exceeds 2^(DATA_W-1)-1, SHALL assert o_err, go SKIP, discard token.
REQ-020 Leading zeros SHALL be accepted ("007" emits 7); no digit-count limit other than REQ-019.
REQ-021 Consecutive delimiters SHALL produce no strobes.
REQ-022 Bytes with i_rx_valid low SHALL be ignored; a token SHALL stay pending indefinitely until a delimiter.
REQ-023 o_num_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-024 i_clear asserted with i_rx_valid in the same cycle: clear wins, byte dropped, next state IDLE, no strobes.
REQ-025 o_num_valid and o_err SHALL never be high in the same cycle.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, accumulator 0, o_num_valid 0, o_num_value 0, o_err 0, o_err_sticky 0, o_num_count 0, independent of clk.

Configuration
REQ-027 Macro NUM_PARSER_NEG_EN defined: '-' (0x2D) in IDLE SHALL enter NUM with a negative flag and empty accumulator; emit SHALL output the negated value; magnitude limit becomes 2^(DATA_W-1) for negative tokens; '-' followed directly by a delimiter, or '-' in NUM, SHALL be an error (o_err, SKIP).
REQ-028 Macro NUM_PARSER_NEG_EN undefined: '-' SHALL be an invalid byte per REQ-013; no negative flag logic present.

Verification
REQ-029 Bytes "2"," ","3"," " -> two o_num_valid strobes, values 2 then 3, o_num_count 2.
REQ-030 Bytes "1","2","x","5"," ","4"," " -> one o_err at 'x', no emit for token, then emit 4; o_err_sticky 1, o_num_count 1.
REQ-031 Bytes "2147483648"," " (DATA_W 32) -> o_err on final '8', no emit; "2147483647"," " -> emit 0x7FFFFFFF.
REQ-032 Bytes "4","5" then i_clear together with " " -> no strobes, o_err_sticky 0, o_num_count 0, next "6"," " emits 6.
REQ-033 With NUM_PARSER_NEG_EN: "-","1","2"," " emits 0xFFFFFFF4; "-"," " gives o_err; without macro "-","1"," " gives o_err, no emit.
REQ-034 rst_n low mid-token "9","9" -> all outputs 0 asynchronously; after release "3"," " emits 3, o_num_count 1.
